data_memory_ctrl: RTL and testbench
===================================

# data_memory_ctrl

Parametrised single-port data memory with a valid/ready request port, byte-lane write enables, a configurable read-latency pipeline and a hardware clear sweep after reset. It replaces the fixed 8×256 data memory in the datapath's memory stage and sits between the load/store unit and the register-file writeback path.

## Interface
- DATA_WIDTH, 8: word width in bits; must be a multiple of 8
- ADDR_WIDTH, 8: address width in bits
- DEPTH, 256: number of words; must satisfy DEPTH ≤ 2^ADDR_WIDTH
- READ_LATENCY, 1: cycles from request accept to rsp_valid; legal range 1..3
- clock  in  1  single clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- req_be  in  DATA_WIDTH/8  byte-lane write enables; ignored for reads
- rsp_valid  out  1  read data valid; one-cycle pulse per read
- rsp_rdata  out  DATA_WIDTH  read data; holds its last value when rsp_valid=0
- busy  out  1  clear sweep in progress
- parity_err  out  1  present only with DMEM_PARITY_EN

## Operation
- States: INIT and RUN.
- reset=1 forces INIT, sets the sweep counter to 0 and flushes the read pipeline. Outputs while reset=1: req_ready=0, rsp_valid=0, rsp_rdata=0, busy=1, parity_err=0.
- INIT:
  - Each cycle, writes zero to word[counter] and increments the counter.
  - After writing word DEPTH-1, moves to RUN on the next edge.
  - busy=1 and req_ready=0 throughout. Requests presented during INIT are not accepted.
- RUN:
  - req_ready=1 and busy=0 every cycle; there is no response back-pressure.
  - Accept = req_valid & req_ready.
- Write accept: for each lane i with req_be[i]=1, byte i of word[req_addr] takes req_wdata byte i at that edge. Lanes with req_be[i]=0 are unchanged. No response is produced.
- Read accept: rsp_valid pulses exactly READ_LATENCY cycles later, with rsp_rdata = word[req_addr] as sampled at the accept edge.
  - Back-to-back reads give back-to-back responses, in order.
- Read-after-write: a read accepted in the cycle after a write to the same address returns the new data. A read and a write cannot be accepted in the same cycle.
- Out-of-range address (req_addr ≥ DEPTH): a write is dropped with no array change; a read responds normally with rsp_rdata=0.
- Reset asserted mid-operation: in-flight responses are discarded (no rsp_valid), array contents are not preserved, and the sweep restarts from word 0.

## Timing
- The clear sweep takes exactly DEPTH cycles after reset deasserts. req_ready first rises in cycle DEPTH, counting the first post-reset edge as cycle 0.
- Read latency is exactly READ_LATENCY cycles, with no data-dependent variation.
- Write latency: the write is visible to a read accepted on the next edge.
- Throughput: one request per cycle in RUN.
- All outputs are registered except req_ready and busy, which decode the state register directly.

## Configuration
- DMEM_PARITY_EN defined:
  - Each byte lane stores one even-parity bit, written on the same edges as the data. The clear sweep writes parity 0.
  - On a read response, parity_err pulses with rsp_valid when any lane's stored parity mismatches. Data is returned unmodified.
- DMEM_PARITY_EN undefined: no parity storage and no parity_err port.

## Structure
- Shared package dmem_pkg holds:
  - the state enum (DMEM_INIT, DMEM_RUN);
  - the localparam LANES = DATA_WIDTH/8;
  - an even-parity function over one byte.
- Sub-module dmem_rd_pipe: a READ_LATENCY-deep shift register carrying a valid bit and the data word (plus the parity flag when DMEM_PARITY_EN is defined). It is flushed by reset.
- The top level owns the array, the FSM, the sweep counter and the write-enable decode.

## Test plan
- Reset then idle, defaults, DEPTH=256: req_ready=0 for cycles 0–255 and 1 at cycle 256; busy mirrors it inverted. A read of address 0x10 then returns 0x00.
- Write 0xA5 to 0x3C with be=1, read 0x3C at READ_LATENCY=2: rsp_valid rises 2 cycles after the read accept with rsp_rdata=0xA5.
- DATA_WIDTH=32: write 0x11223344 with be=4'hF, then write 0xAABBCCDD with be=4'b0101, read back: 0x11BB33DD.
- Back-to-back: write A then read A on consecutive cycles returns the new value. Four consecutive reads produce four consecutive rsp_valid pulses in address order.
- DEPTH=200, ADDR_WIDTH=8: a write to 0xF0 is dropped and the contents of address 0x70 stay unchanged; a read of 0xF0 returns 0.
- Reset pulsed while two reads are in flight: no rsp_valid appears, and the sweep restarts with busy=1 for DEPTH cycles. With DMEM_PARITY_EN defined, force a stored parity bit flip and read: parity_err=1 coincident with rsp_valid.

Source files
------------

// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and helpers for the data_memory_ctrl slice.
//   dmem_state_e : controller state (clear sweep vs. normal operation)
//   LANES        : byte lanes for the default 8-bit word
//   lanes_of()   : byte lanes for an arbitrary word width
//   even_parity(): parity bit that makes the number of ones in a byte even
// -----------------------------------------------------------------------------
package dmem_pkg;

  typedef enum logic {
    DMEM_INIT = 1'b0,
    DMEM_RUN  = 1'b1
  } dmem_state_e;

  localparam int DMEM_DEFAULT_DATA_WIDTH = 8;
  localparam int LANES = DMEM_DEFAULT_DATA_WIDTH / 8;

  function automatic int lanes_of(input int data_width);
    return data_width / 8;
  endfunction

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// -----------------------------------------------------------------------------
// dmem_rd_pipe
// LATENCY-deep read response pipeline. Each stage carries a valid bit and the
// data word (plus a parity-error flag when DMEM_PARITY_EN is defined). Data
// registers only load behind a valid entry, so out_data holds the last
// response while out_valid is low. Synchronous reset flushes every stage.
// Ports:
//   clock, reset          : clock / synchronous active-high reset
//   in_valid, in_data     : read accepted this edge and the word read
//   in_perr               : stored-parity mismatch (DMEM_PARITY_EN only)
//   out_valid, out_data   : response, LATENCY edges after acceptance
//   out_perr              : parity-error flag aligned to out_valid
// Optional feature macro: DMEM_PARITY_EN
// -----------------------------------------------------------------------------
module dmem_rd_pipe #(
  parameter int W       = 8,
  parameter int LATENCY = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
`ifdef DMEM_PARITY_EN
  input  logic         in_perr,
  output logic         out_perr,
`endif
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [LATENCY-1:0] vld;
  logic [W-1:0]       dat [LATENCY];
`ifdef DMEM_PARITY_EN
  logic [LATENCY-1:0] perr;
`endif

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the value its predecessor held before this edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < LATENCY; i++) dat[i] <= '0;
`ifdef DMEM_PARITY_EN
      perr <= '0;
`endif
    end else begin
      vld[0] <= in_valid;
      if (in_valid) dat[0] <= in_data;
`ifdef DMEM_PARITY_EN
      perr[0] <= in_valid & in_perr;
`endif
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) dat[i] <= dat[i-1];
`ifdef DMEM_PARITY_EN
        perr[i] <= vld[i-1] & perr[i-1];
`endif
      end
    end
  end

  assign out_valid = vld[LATENCY-1];
  assign out_data  = dat[LATENCY-1];
`ifdef DMEM_PARITY_EN
  assign out_perr  = perr[LATENCY-1];
`endif

endmodule

// File: rtl/data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// data_memory_ctrl
// Single-port data memory with a valid/ready request port, byte-lane write
// enables, a READ_LATENCY-deep read pipeline and a clear sweep after reset.
// After reset the array is zeroed one word per cycle (busy=1, req_ready=0);
// then one read or write is accepted per cycle. Out-of-range writes are
// dropped; out-of-range reads return zero.
// Ports:
//   clock, reset       : clock / synchronous active-high reset
//   req_valid/ready    : request handshake (ready only outside the sweep)
//   req_write          : 1 = write, 0 = read
//   req_addr/wdata/be  : word address, write data, byte-lane enables
//   rsp_valid/rdata    : read response (rdata holds between responses)
//   busy               : clear sweep in progress
//   parity_err         : stored-parity mismatch on a response
//                        (only with DMEM_PARITY_EN)
// Optional feature macro: DMEM_PARITY_EN (per-lane even parity storage)
// -----------------------------------------------------------------------------
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    busy
`ifdef DMEM_PARITY_EN
  ,
  output logic                    parity_err
`endif
);

  localparam int NL = lanes_of(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH - 1);

  dmem_state_e           state, state_nxt;
  logic [ADDR_WIDTH-1:0] sweep_cnt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
`ifdef DMEM_PARITY_EN
  logic [NL-1:0]         par_mem [DEPTH];
  logic                  rd_perr;
`endif

  logic                  addr_ok, wr_acc, rd_acc;
  logic [NL-1:0]         lane_we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_word;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clock) begin
    if (reset) state <= DMEM_INIT;
    else       state <= state_nxt;
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      DMEM_INIT: if (sweep_cnt == LAST_WORD) state_nxt = DMEM_RUN;
      DMEM_RUN:  state_nxt = DMEM_RUN;
      default:   state_nxt = DMEM_INIT;
    endcase
  end

  // Word index of the clear sweep; only advances while sweeping.
  always_ff @(posedge clock) begin
    if (reset)                  sweep_cnt <= '0;
    else if (state == DMEM_INIT) sweep_cnt <= sweep_cnt + 1'b1;
  end

  assign req_ready = (state == DMEM_RUN);
  assign busy      = (state == DMEM_INIT);

  // ------------------------------------------------------- request decode
  assign addr_ok = ({1'b0, req_addr} < (ADDR_WIDTH + 1)'(DEPTH));
  assign wr_acc  = req_valid & req_ready &  req_write;
  assign rd_acc  = req_valid & req_ready & ~req_write;

  // The sweep and functional writes share one write port; the sweep owns it
  // while busy, since requests are never accepted then.
  always_comb begin
    lane_we = '0;
    wr_addr = sweep_cnt;
    wr_data = '0;
    if (!reset) begin
      if (state == DMEM_INIT) begin
        lane_we = '1;
      end else if (wr_acc && addr_ok) begin
        lane_we = req_be;
        wr_addr = req_addr;
        wr_data = req_wdata;
      end
    end
  end

  // NOTE: the array itself has no reset; after reset the sweep zeroes it.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NL; i++) begin
      if (lane_we[i]) begin
        mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
`ifdef DMEM_PARITY_EN
        par_mem[wr_addr][i] <= even_parity(wr_data[8*i +: 8]);
`endif
      end
    end
  end

  // ------------------------------------------------------------ read path
  // The array is sampled at the accept edge; the pipeline adds the latency.
  assign rd_word = addr_ok ? mem[req_addr] : '0;

`ifdef DMEM_PARITY_EN
  always_comb begin
    rd_perr = 1'b0;
    if (addr_ok) begin
      for (int i = 0; i < NL; i++) begin
        if (par_mem[req_addr][i] != even_parity(mem[req_addr][8*i +: 8])) rd_perr = 1'b1;
      end
    end
  end
`endif

  dmem_rd_pipe #(
    .W       (DATA_WIDTH),
    .LATENCY (READ_LATENCY)
  ) u_rd_pipe (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (rd_acc),
    .in_data   (rd_word),
`ifdef DMEM_PARITY_EN
    .in_perr   (rd_perr),
    .out_perr  (parity_err),
`endif
    .out_valid (rsp_valid),
    .out_data  (rsp_rdata)
  );

endmodule

// File: tb/tb_data_memory_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_memory_ctrl
// Self-checking bench for data_memory_ctrl (32-bit words, 200 of 256
// addresses populated, three-cycle read latency). A word-array model with a
// queue of expected responses is checked against the DUT on every falling
// edge; directed sequences pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_data_memory_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int DEPTH = 200;
  localparam int RL = 3;
  localparam int NL = DW / 8;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [NL-1:0] req_be = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
`ifdef DMEM_PARITY_EN
  logic          parity_err;
`endif

  data_memory_ctrl #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .DEPTH        (DEPTH),
    .READ_LATENCY (RL)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy)
`ifdef DMEM_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clock = ~clock;

  // ---------------------------------------------------------------- model
  typedef struct {
    int          due;
    logic [DW-1:0] data;
    logic        perr;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  logic          flipped [DEPTH];
  logic [DW-1:0] last_data = '0;
  int            ncount = 0;
  int            rsp_seen = 0;
  bit            chk_en = 1'b0;

  int tests = 0;
  int fails = 0;

  always @(posedge clock) ncount <= ncount + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One compare process: every falling edge, the response port must match the
  // oldest outstanding read whose due cycle has arrived, else stay quiet.
  always @(negedge clock) begin
    if (chk_en) begin
      logic exp_v;
      logic exp_p;
      exp_v = (exp_q.size() > 0) && (exp_q[0].due == ncount);
      exp_p = 1'b0;
      if (exp_v) begin
        exp_t e;
        e = exp_q.pop_front();
        last_data = e.data;
        exp_p = e.perr;
      end
      if (rsp_valid) rsp_seen++;
      check("rsp_valid", {63'd0, rsp_valid}, {63'd0, exp_v});
      check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, last_data});
`ifdef DMEM_PARITY_EN
      check("parity_err", {63'd0, parity_err}, {63'd0, exp_p});
`endif
    end
  end

  // Present one request at the current falling edge, record its effect on the
  // model if it will be accepted, and advance to the next falling edge.
  task automatic issue(input logic w, input int a, input logic [DW-1:0] d, input logic [NL-1:0] be);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = AW'(a);
    req_wdata = d;
    req_be    = be;
    if (req_ready) begin
      if (w) begin
        if (a < DEPTH) begin
          for (int i = 0; i < NL; i++)
            if (be[i]) model_mem[a][8*i +: 8] = d[8*i +: 8];
          if (be[0]) flipped[a] = 1'b0;
        end
      end else begin
        exp_q.push_back('{due: ncount + RL,
                          data: (a < DEPTH) ? model_mem[a] : '0,
                          perr: (a < DEPTH) ? flipped[a] : 1'b0});
      end
    end
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic read_wait(input int a, output logic [DW-1:0] d, output int lat);
    issue(1'b0, a, '0, '0);
    lat = 1;
    while (!rsp_valid && lat < 12) begin
      @(negedge clock);
      lat++;
    end
    if (!rsp_valid) check("read_timeout", 64'd0, 64'd1);
    d = rsp_rdata;
  endtask

  // Release reset at this falling edge and track the clear sweep: the first
  // post-reset rising edge is cycle 0, requests are first accepted at cycle DEPTH.
  task automatic release_and_sweep();
    reset  = 1'b0;
    chk_en = 1'b1;
    for (int k = 0; k <= DEPTH; k++) begin
      check($sformatf("sweep_ready_c%0d", k), {63'd0, req_ready}, (k >= DEPTH) ? 64'd1 : 64'd0);
      check($sformatf("sweep_busy_c%0d", k),  {63'd0, busy},      (k >= DEPTH) ? 64'd0 : 64'd1);
      if (k < DEPTH) @(negedge clock);
    end
  endtask

  task automatic reset_pulse();
    chk_en = 1'b0;
    reset  = 1'b1;
    exp_q.delete();
    last_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = '0;
      flipped[i]   = 1'b0;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    end
    check("reset_req_ready", {63'd0, req_ready}, 64'd0);
    check("reset_busy",      {63'd0, busy},      64'd1);
    check("reset_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
`ifdef DMEM_PARITY_EN
    check("reset_parity_err", {63'd0, parity_err}, 64'd0);
`endif
    release_and_sweep();
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    logic [DW-1:0] d;
    int lat;
    int seen0;

    @(negedge clock);
    reset_pulse();

    // Idle read after the sweep returns the cleared value.
    read_wait(16'h10, d, lat);
    check("clear_read_0x10", {32'd0, d}, 64'h0);
    check("clear_read_lat", 64'(lat), 64'(RL));

    // Single-lane write then read.
    issue(1'b1, 8'h3C, 32'h0000_00A5, 4'b0001);
    read_wait(8'h3C, d, lat);
    check("be1_read_0x3C", {32'd0, d}, 64'h0000_00A5);
    check("be1_read_lat", 64'(lat), 64'(RL));

    // Partial byte-lane merge.
    issue(1'b1, 8'h40, 32'h1122_3344, 4'hF);
    issue(1'b1, 8'h40, 32'hAABB_CCDD, 4'b0101);
    read_wait(8'h40, d, lat);
    check("lane_merge_0x40", {32'd0, d}, 64'h11BB_33DD);

    // Read-after-write on consecutive cycles, then four back-to-back reads.
    issue(1'b1, 8'h20, 32'h0000_0001, 4'hF);
    issue(1'b1, 8'h21, 32'h0000_0002, 4'hF);
    issue(1'b1, 8'h22, 32'h0000_0003, 4'hF);
    issue(1'b1, 8'h23, 32'h0000_0004, 4'hF);
    seen0 = rsp_seen;
    issue(1'b1, 8'h24, 32'h5555_AAAA, 4'hF);
    issue(1'b0, 8'h24, '0, '0);
    for (int i = 0; i < 4; i++) issue(1'b0, 8'h20 + i, '0, '0);
    repeat (RL + 1) @(negedge clock);
    check("b2b_rsp_count", 64'(rsp_seen - seen0), 64'd5);

    // Out-of-range write must not alias onto an in-range word.
    issue(1'b1, 8'h70, 32'hCAFE_F00D, 4'hF);
    issue(1'b1, 8'hF0, 32'hDEAD_BEEF, 4'hF);
    read_wait(8'h70, d, lat);
    check("oor_keep_0x70", {32'd0, d}, 64'hCAFE_F00D);
    read_wait(8'hF0, d, lat);
    check("oor_read_0xF0", {32'd0, d}, 64'h0);

    // Randomised traffic, including idles and out-of-range addresses.
    for (int n = 0; n < 600; n++) begin
      int op;
      op = $urandom_range(0, 3);
      if (op == 0) @(negedge clock);
      else issue(op == 1, $urandom_range(0, 255), $urandom, NL'($urandom));
    end
    repeat (RL + 1) @(negedge clock);

`ifdef DMEM_PARITY_EN
    // Corrupt one stored parity bit: the response flags it, data unchanged.
    issue(1'b1, 8'h07, 32'h0102_0304, 4'hF);
    dut.par_mem[7][0] = ~dut.par_mem[7][0];
    flipped[7] = 1'b1;
    read_wait(8'h07, d, lat);
    check("parity_err_flag", {63'd0, parity_err}, 64'd1);
    check("parity_err_data", {32'd0, d}, 64'h0102_0304);
    @(negedge clock);
`endif

    // Reset while two reads are in flight: both responses are discarded and
    // the sweep runs again, clearing earlier contents.
    issue(1'b0, 8'h3C, '0, '0);
    issue(1'b0, 8'h40, '0, '0);
    reset_pulse();
    read_wait(8'h3C, d, lat);
    check("post_reset_0x3C", {32'd0, d}, 64'h0);

    repeat (RL + 2) @(negedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
